// File: rtl/i2c_sched_pkg.sv
// rtl/i2c_sched_pkg.sv - state encodings and wrapper cfg addresses for i2c_txn_scheduler
package i2c_sched_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] S_GRANT     = 4'd1;
    localparam logic [STATE_W-1:0] S_WR_LEN    = 4'd2;
    localparam logic [STATE_W-1:0] S_WR_D0     = 4'd3;
    localparam logic [STATE_W-1:0] S_WR_D1     = 4'd4;
    localparam logic [STATE_W-1:0] S_WR_CTRL   = 4'd5;
    localparam logic [STATE_W-1:0] S_WAIT_BUSY = 4'd6;
    localparam logic [STATE_W-1:0] S_WAIT_DONE = 4'd7;
    localparam logic [STATE_W-1:0] S_FINISH    = 4'd8;

    // I2C master wrapper register window on the internal cfg bus
    localparam logic [15:0] I2C_BASE_ADDR    = 16'h0400;
    localparam logic [15:0] I2C_LEN_OFS      = 16'h0000;
    localparam logic [15:0] I2C_TX_DATA0_OFS = 16'h0004;
    localparam logic [15:0] I2C_TX_DATA1_OFS = 16'h0008;
    localparam logic [15:0] I2C_CTRL_OFS     = 16'h000C;

    localparam logic [15:0] I2C_LEN_ADDR      = I2C_BASE_ADDR + I2C_LEN_OFS;
    localparam logic [15:0] I2C_TX_DATA0_ADDR = I2C_BASE_ADDR + I2C_TX_DATA0_OFS;
    localparam logic [15:0] I2C_TX_DATA1_ADDR = I2C_BASE_ADDR + I2C_TX_DATA1_OFS;
    localparam logic [15:0] I2C_CTRL_ADDR     = I2C_BASE_ADDR + I2C_CTRL_OFS;

    // CTRL word: slave address with the start bit in bit 0
    function automatic logic [31:0] ctrl_word(input logic [6:0] addr);
        return {24'b0, addr, 1'b1};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from rr_ptr+1
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant
);

    logic found;
    int   idx;

    // first set request after the last owner wins; at most one bit is set
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// rtl/i2c_txn_scheduler.sv - shares one I2C master wrapper among NREQ requesters; optional I2C_SCHED_TIMEOUT_EN
import i2c_sched_pkg::*;

module i2c_txn_scheduler #(
    parameter int NREQ           = 2,
    parameter int BUSY_WAIT      = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*7-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_wlen,
    input  logic [NREQ*8-1:0] req_rlen,
    input  logic [NREQ*64-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        rsp_data,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [15:0]       cfg_addr,
    output logic [31:0]       cfg_wdata,
    output logic              cfg_write,
    input  logic              i2c_busy,
    input  logic [7:0]        i2c_rdata,
    input  logic              i2c_rvalid
);

    localparam int PW  = $clog2(NREQ);
    localparam int BCW = $clog2(BUSY_WAIT + 1);

    logic [STATE_W-1:0] state;
    logic [PW-1:0]      owner;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      win_idx;
    logic [NREQ-1:0]    win_oh;
    logic [NREQ-1:0]    owner_oh;
    logic [6:0]         addr_q;
    logic [7:0]         wlen_q;
    logic [7:0]         rlen_q;
    logic [63:0]        wdata_q;
    logic [7:0]         rcnt;
    logic [7:0]         rcnt_next;
    logic [BCW-1:0]     bcnt;
    logic               rd_accept;
    logic               rd_short;
    logic               idle_ok;

`ifdef I2C_SCHED_TIMEOUT_EN
    logic [19:0]        tcnt;
    // a timed-out wrapper may still be busy; hold off the next grant until it settles
    assign idle_ok = !i2c_busy;
`else
    assign idle_ok = 1'b1;
`endif

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (win_oh)
    );

    // encode the one-hot winner to an index for descriptor slicing
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) win_idx = PW'(i);
        end
    end

    assign owner_oh  = NREQ'(1) << owner;
    assign rd_accept = ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) &&
                       i2c_rvalid && (rcnt < rlen_q);
    assign rcnt_next = rcnt + {7'b0, rd_accept};
    assign rd_short  = (rcnt_next != rlen_q);

    // transaction FSM; every output is a flop loaded on the edge entering its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= PW'(NREQ - 1);
            addr_q    <= '0;
            wlen_q    <= '0;
            rlen_q    <= '0;
            wdata_q   <= '0;
            rcnt      <= '0;
            bcnt      <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rsp_data  <= '0;
            rsp_valid <= '0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            cfg_write <= 1'b0;
`ifdef I2C_SCHED_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            rsp_valid <= '0;
            cfg_write <= 1'b0;
            rcnt      <= rcnt_next;
            if (rd_accept) begin
                rsp_data  <= i2c_rdata;
                rsp_valid <= owner_oh;
            end
            case (state)
                S_IDLE: begin
                    if ((|req) && idle_ok) begin
                        state   <= S_GRANT;
                        owner   <= win_idx;
                        gnt     <= win_oh;
                        addr_q  <= req_addr[7*win_idx +: 7];
                        wlen_q  <= req_wlen[8*win_idx +: 8];
                        rlen_q  <= req_rlen[8*win_idx +: 8];
                        wdata_q <= req_wdata[64*win_idx +: 64];
                        rcnt    <= '0;
                    end
                end
                S_GRANT: begin
                    rr_ptr <= owner;
                    if ((wlen_q > 8'd8) || ((wlen_q == 8'd0) && (rlen_q == 8'd0))) begin
                        state <= S_FINISH;
                        done  <= owner_oh;
                        err   <= owner_oh;
                    end else begin
                        state     <= S_WR_LEN;
                        cfg_write <= 1'b1;
                        cfg_addr  <= I2C_LEN_ADDR;
                        cfg_wdata <= {16'b0, wlen_q, rlen_q};
                    end
                end
                S_WR_LEN: begin
                    state     <= S_WR_D0;
                    cfg_write <= 1'b1;
                    cfg_addr  <= I2C_TX_DATA0_ADDR;
                    cfg_wdata <= wdata_q[31:0];
                end
                S_WR_D0: begin
                    state     <= S_WR_D1;
                    cfg_write <= 1'b1;
                    cfg_addr  <= I2C_TX_DATA1_ADDR;
                    cfg_wdata <= wdata_q[63:32];
                end
                S_WR_D1: begin
                    state     <= S_WR_CTRL;
                    cfg_write <= 1'b1;
                    cfg_addr  <= I2C_CTRL_ADDR;
                    cfg_wdata <= ctrl_word(addr_q);
                end
                S_WR_CTRL: begin
                    state <= S_WAIT_BUSY;
                    bcnt  <= '0;
                end
                S_WAIT_BUSY: begin
                    if (i2c_busy) begin
                        state <= S_WAIT_DONE;
`ifdef I2C_SCHED_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                    end else if (bcnt == BCW'(BUSY_WAIT - 1)) begin
                        state <= S_FINISH;
                        done  <= owner_oh;
                        err   <= owner_oh;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i2c_busy) begin
                        state <= S_FINISH;
                        done  <= owner_oh;
                        err   <= rd_short ? owner_oh : '0;
`ifdef I2C_SCHED_TIMEOUT_EN
                    end else if (tcnt == 20'(TIMEOUT_CYCLES - 1)) begin
                        state <= S_FINISH;
                        done  <= owner_oh;
                        err   <= owner_oh;
                    end else begin
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb/tb_i2c_txn_scheduler.sv - directed self-checking bench for i2c_txn_scheduler
module tb_i2c_txn_scheduler;

    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*7-1:0] req_addr = '0;
    logic [NREQ*8-1:0] req_wlen = '0;
    logic [NREQ*8-1:0] req_rlen = '0;
    logic [NREQ*64-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt, done, err, rsp_valid;
    logic [7:0]        rsp_data;
    logic [15:0]       cfg_addr;
    logic [31:0]       cfg_wdata;
    logic              cfg_write;
    logic              i2c_busy = 1'b0;
    logic [7:0]        i2c_rdata = '0;
    logic              i2c_rvalid = 1'b0;

    i2c_txn_scheduler #(.NREQ(NREQ), .BUSY_WAIT(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_wlen(req_wlen),
        .req_rlen(req_rlen), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_write(cfg_write), .i2c_busy(i2c_busy),
        .i2c_rdata(i2c_rdata), .i2c_rvalid(i2c_rvalid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          gnt_log[$];
    int          done_log[$];
    int          err_log[$];
    int          done_cyc[$];
    int          rsp_idx[$];
    logic [7:0]  rsp_val[$];

    always @(posedge clk) cyc <= cyc + 1;

    // observe DUT outputs mid-cycle and log every event
    always @(negedge clk) begin
        if (cfg_write) begin
            wr_addr.push_back(cfg_addr);
            wr_data.push_back(cfg_wdata);
            wr_cyc.push_back(cyc);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_log.push_back(i);
            if (done[i]) begin
                done_log.push_back(i);
                err_log.push_back(int'(err[i]));
                done_cyc.push_back(cyc);
            end
            if (rsp_valid[i]) begin
                rsp_idx.push_back(i);
                rsp_val.push_back(rsp_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k;
        k = 0;
        while (wr_addr.size() < n && k < 40) begin
            tick(1);
            k++;
        end
        chk(tag, 64'(wr_addr.size() >= n), 64'd1);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (done_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 64'(done_log.size() >= n), 64'd1);
    endtask

    task automatic set_desc(input int i, input logic [6:0] a, input logic [7:0] wl,
                            input logic [7:0] rl, input logic [63:0] wd);
        req_addr[7*i +: 7]   = a;
        req_wlen[8*i +: 8]   = wl;
        req_rlen[8*i +: 8]   = rl;
        req_wdata[64*i +: 64] = wd;
    endtask

    // wrapper behaviour for a plain write: busy high for a few cycles after CTRL
    task automatic serve_write(input int nwr, input int nd, input int busy_len, input string tag);
        wait_writes(nwr, {tag, "_wr"});
        i2c_busy = 1'b1;
        tick(busy_len);
        i2c_busy = 1'b0;
        wait_done(nd, 20, {tag, "_done"});
    endtask

    initial begin
        tick(2);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cfg_write", 64'(cfg_write), 64'd0);
        chk("rst_cfg_addr", 64'(cfg_addr), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // write transaction from requester 0
        set_desc(0, 7'h50, 8'd2, 8'd0, 64'hABCD);
        req = 2'b01;
        wait_writes(4, "w_wr");
        chk("w_gnt", 64'(gnt_log[0]), 64'd0);
        chk("w_a0", 64'(wr_addr[0]), 64'h0400);
        chk("w_a3", 64'(wr_addr[3]), 64'h040C);
        chk("w_d0", 64'(wr_data[0]), 64'h0200);
        chk("w_d1", 64'(wr_data[1]), 64'hABCD);
        chk("w_d2", 64'(wr_data[2]), 64'h0);
        chk("w_d3", 64'(wr_data[3]), 64'hA1);
        chk("w_consec", 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);
        i2c_busy = 1'b1;
        tick(20);
        chk("w_no_early_done", 64'(done_log.size()), 64'd0);
        i2c_busy = 1'b0;
        wait_done(1, 20, "w_done");
        req = 2'b00;
        chk("w_done_idx", 64'(done_log[0]), 64'd0);
        chk("w_err", 64'(err_log[0]), 64'd0);
        tick(3);

        // read transaction from requester 1; the third byte exceeds rlen and is dropped
        set_desc(1, 7'h3C, 8'd1, 8'd2, 64'h5A);
        req = 2'b10;
        wait_writes(8, "r_wr");
        chk("r_gnt", 64'(gnt_log[1]), 64'd1);
        chk("r_len", 64'(wr_data[4]), 64'h0102);
        chk("r_ctrl", 64'(wr_data[7]), 64'h79);
        i2c_busy = 1'b1;
        tick(2);
        i2c_rdata = 8'h11; i2c_rvalid = 1'b1; tick(1);
        i2c_rvalid = 1'b0; tick(2);
        i2c_rdata = 8'h22; i2c_rvalid = 1'b1; tick(1);
        i2c_rdata = 8'h33; tick(1);
        i2c_rvalid = 1'b0; tick(1);
        i2c_busy = 1'b0;
        wait_done(2, 20, "r_done");
        req = 2'b00;
        chk("r_rsp_cnt", 64'(rsp_idx.size()), 64'd2);
        chk("r_rsp0_idx", 64'(rsp_idx[0]), 64'd1);
        chk("r_rsp0", 64'(rsp_val[0]), 64'h11);
        chk("r_rsp1", 64'(rsp_val[1]), 64'h22);
        chk("r_done_idx", 64'(done_log[1]), 64'd1);
        chk("r_err", 64'(err_log[1]), 64'd0);
        tick(3);

        // contention from reset: both held, grants alternate 0,1,0
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        set_desc(0, 7'h10, 8'd1, 8'd0, 64'h1);
        set_desc(1, 7'h20, 8'd1, 8'd0, 64'h2);
        req = 2'b11;
        serve_write(12, 3, 3, "c1");
        serve_write(16, 4, 3, "c2");
        serve_write(20, 5, 3, "c3");
        req = 2'b00;
        chk("c_gnt0", 64'(gnt_log[2]), 64'd0);
        chk("c_gnt1", 64'(gnt_log[3]), 64'd1);
        chk("c_gnt2", 64'(gnt_log[4]), 64'd0);
        chk("c_err", 64'(err_log[2] + err_log[3] + err_log[4]), 64'd0);
        chk("c_gap", 64'(wr_cyc[16] - done_cyc[3] >= 3), 64'd1);
        tick(3);

        // bad lengths: wlen=9, then wlen=0/rlen=0; no cfg writes either time
        set_desc(0, 7'h50, 8'd9, 8'd0, 64'h0);
        req = 2'b01;
        wait_done(6, 20, "bl_done");
        req = 2'b00;
        chk("bl_gnt", 64'(gnt_log.size()), 64'd6);
        chk("bl_err", 64'(err_log[5]), 64'd1);
        tick(2);
        set_desc(0, 7'h50, 8'd0, 8'd0, 64'h0);
        req = 2'b01;
        wait_done(7, 20, "z_done");
        req = 2'b00;
        chk("z_err", 64'(err_log[6]), 64'd1);
        chk("bl_no_wr", 64'(wr_addr.size()), 64'd20);
        tick(3);

        // read NACK: busy pulses but no bytes come back
        set_desc(1, 7'h44, 8'd0, 8'd3, 64'h0);
        req = 2'b10;
        serve_write(24, 8, 5, "nk");
        req = 2'b00;
        chk("nk_err", 64'(err_log[7]), 64'd1);
        chk("nk_idx", 64'(done_log[7]), 64'd1);
        tick(3);

        // busy never rises: err exactly 9 cycles after the CTRL write
        req = 2'b10;
        wait_writes(28, "nb_wr");
        wait_done(9, 30, "nb_done");
        req = 2'b00;
        chk("nb_err", 64'(err_log[8]), 64'd1);
        chk("nb_lat", 64'(done_cyc[8] - wr_cyc[27]), 64'd9);
        tick(3);

`ifdef I2C_SCHED_TIMEOUT_EN
        // busy stuck high: timeout error, then no grant until busy drops
        set_desc(0, 7'h50, 8'd1, 8'd0, 64'h7);
        req = 2'b01;
        wait_writes(32, "to_wr");
        i2c_busy = 1'b1;
        wait_done(10, 150, "to_done");
        req = 2'b00;
        chk("to_err", 64'(err_log[9]), 64'd1);
        chk("to_lat", 64'(done_cyc[9] - wr_cyc[31]), 64'd102);
        tick(2);
        req = 2'b01;
        tick(10);
        chk("to_hold", 64'(gnt_log.size()), 64'd10);
        i2c_busy = 1'b0;
        tick(4);
        chk("to_regrant", 64'(gnt_log.size()), 64'd11);
        serve_write(36, 11, 2, "to2");
        req = 2'b00;
        tick(3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
